// File: rtl/led_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_sweep_ctrl
// Brief    : LED sweep game sequencer (IDLE/RUN/HOLD) feeding a 4-to-16 decoder.
//            Optional macro SWEEP_BOUNCE_EN selects ping-pong sweep instead of wrap.
// Revision : 1.0 - initial release
// ============================================================================
module led_sweep_ctrl #(
    parameter int         TICK_LOW    = 50_000_000,
    parameter int         TICK_NORMAL = 25_000_000,
    parameter int         TICK_HIGH   = 10_000_000,
    parameter int         HOLD_CYCLES = 100_000_000,
    parameter logic [3:0] TARGET      = 4'd7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic [1:0] mode_sel,
    output logic [3:0] I,
    output logic       start,
    output logic       idle,
    output logic [1:0] mode,
    output logic [3:0] score,
    output logic       hit
);

    localparam int c_tick_w = $clog2(TICK_LOW + 1);
    localparam int c_hold_w = $clog2(HOLD_CYCLES + 1);

    localparam logic [c_tick_w-1:0] c_low_last    = c_tick_w'(TICK_LOW - 1);
    localparam logic [c_tick_w-1:0] c_normal_last = c_tick_w'(TICK_NORMAL - 1);
    localparam logic [c_tick_w-1:0] c_high_last   = c_tick_w'(TICK_HIGH - 1);
    localparam logic [c_hold_w-1:0] c_hold_last   = c_hold_w'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_i, w_i_nxt;
    logic [1:0]          r_mode, w_mode_nxt;
    logic [3:0]          r_score, w_score_nxt;
    logic                r_hit, w_hit_nxt;
    logic                r_start, r_idle;
    logic [c_tick_w-1:0] r_tick, w_tick_nxt;
    logic [c_hold_w-1:0] r_hold, w_hold_nxt;
    logic [c_tick_w-1:0] w_tick_last;
    logic                w_step;
    logic [3:0]          w_i_step;

    always_comb begin
        case (r_mode)
            2'b10:   w_tick_last = c_normal_last;
            2'b11:   w_tick_last = c_high_last;
            default: w_tick_last = c_low_last;
        endcase
    end

    assign w_step = (r_tick == w_tick_last);

`ifdef SWEEP_BOUNCE_EN
    logic r_dir_up, w_dir_up_nxt, w_dir_up_step;

    // Reversal happens on the step that leaves an endpoint, so each end is shown one period.
    always_comb begin
        w_i_step      = r_i;
        w_dir_up_step = r_dir_up;
        if (r_dir_up) begin
            if (r_i == 4'd15) begin
                w_i_step      = 4'd14;
                w_dir_up_step = 1'b0;
            end else begin
                w_i_step = r_i + 4'd1;
            end
        end else begin
            if (r_i == 4'd0) begin
                w_i_step      = 4'd1;
                w_dir_up_step = 1'b1;
            end else begin
                w_i_step = r_i - 4'd1;
            end
        end
    end
`else
    assign w_i_step = r_i + 4'd1;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_mode_nxt  = r_mode;
        w_score_nxt = r_score;
        w_hit_nxt   = 1'b0;
        w_tick_nxt  = r_tick;
        w_hold_nxt  = r_hold;
`ifdef SWEEP_BOUNCE_EN
        w_dir_up_nxt = r_dir_up;
`endif
        case (r_state)
            ST_IDLE: begin
                w_mode_nxt = mode_sel;
                if (btn_start && (mode_sel != 2'b00)) begin
                    w_state_nxt = ST_RUN;
                    w_i_nxt     = 4'd0;
                    w_tick_nxt  = '0;
                    w_hold_nxt  = '0;
                    w_score_nxt = 4'd0;
`ifdef SWEEP_BOUNCE_EN
                    w_dir_up_nxt = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                // Abort outranks stop, and stop outranks a coincident step tick.
                if (btn_start) begin
                    w_state_nxt = ST_IDLE;
                    w_i_nxt     = 4'd0;
                    w_tick_nxt  = '0;
                    w_hold_nxt  = '0;
                end else if (btn_stop) begin
                    w_state_nxt = ST_HOLD;
                    w_tick_nxt  = '0;
                    w_hold_nxt  = '0;
                    if (r_i == TARGET) begin
                        w_hit_nxt = 1'b1;
                        if (r_score != 4'hF) begin
                            w_score_nxt = r_score + 4'd1;
                        end
                    end
                end else if (w_step) begin
                    w_tick_nxt = '0;
                    w_i_nxt    = w_i_step;
`ifdef SWEEP_BOUNCE_EN
                    w_dir_up_nxt = w_dir_up_step;
`endif
                end else begin
                    w_tick_nxt = r_tick + c_tick_w'(1);
                end
            end
            ST_HOLD: begin
                if (btn_start) begin
                    w_state_nxt = ST_IDLE;
                    w_i_nxt     = 4'd0;
                    w_tick_nxt  = '0;
                    w_hold_nxt  = '0;
                end else if (r_hold == c_hold_last) begin
                    w_state_nxt = ST_RUN;
                    w_i_nxt     = 4'd0;
                    w_tick_nxt  = '0;
                    w_hold_nxt  = '0;
`ifdef SWEEP_BOUNCE_EN
                    w_dir_up_nxt = 1'b1;
`endif
                end else begin
                    w_hold_nxt = r_hold + c_hold_w'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_i_nxt     = 4'd0;
                w_tick_nxt  = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_i     <= 4'd0;
            r_mode  <= 2'b00;
            r_score <= 4'd0;
            r_hit   <= 1'b0;
            r_start <= 1'b0;
            r_idle  <= 1'b1;
            r_tick  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_i     <= w_i_nxt;
            r_mode  <= w_mode_nxt;
            r_score <= w_score_nxt;
            r_hit   <= w_hit_nxt;
            r_start <= (w_state_nxt != ST_IDLE);
            r_idle  <= (w_state_nxt == ST_IDLE);
            r_tick  <= w_tick_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

`ifdef SWEEP_BOUNCE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dir_up <= 1'b1;
        end else begin
            r_dir_up <= w_dir_up_nxt;
        end
    end
`endif

    assign I     = r_i;
    assign start = r_start;
    assign idle  = r_idle;
    assign mode  = r_mode;
    assign score = r_score;
    assign hit   = r_hit;

endmodule
`default_nettype wire

// File: doc/led_sweep_ctrl.md
# led_sweep_ctrl

Game sequencer that produces the LED index, start/idle flags and speed mode consumed by the 4-to-16 LED decoder. In idle it shows the selected speed mode; once started it sweeps a lit position across the 16 LEDs at a mode-dependent rate. A stop button freezes the position and scores a hit if the frozen position equals the target LED. All outputs are registered; the decoder stage downstream is purely combinational.

## Interface
- TICK_LOW, 50_000_000, clk cycles per position step in mode Low (2'b01)
- TICK_NORMAL, 25_000_000, cycles per step in mode Normal (2'b10)
- TICK_HIGH, 10_000_000, cycles per step in mode High (2'b11); require TICK_LOW >= TICK_NORMAL >= TICK_HIGH >= 1
- HOLD_CYCLES, 100_000_000, cycles the frozen position is held after a stop (>= 1)
- TARGET, 4'd7, LED index that scores a hit
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- btn_start  in  1  one-cycle pulse, already debounced and synchronised; start or abort
- btn_stop  in  1  one-cycle pulse, already debounced and synchronised; freeze the sweep
- mode_sel  in  2  speed switches; 2'b00 means no mode selected
- I  out  4  current LED index to the decoder
- start  out  1  high in RUN and HOLD
- idle  out  1  high in IDLE
- mode  out  2  latched speed mode
- score  out  4  hit count, saturating at 15
- hit  out  1  one-cycle pulse on a scoring stop

## Operation
- States: IDLE, RUN, HOLD. Reset enters IDLE with I=0, start=0, idle=1, mode=2'b00, score=0, hit=0, and tick and hold counters at 0.
- IDLE: mode <= mode_sel every cycle. On btn_start with mode_sel != 2'b00, go to RUN with mode latched from mode_sel, I=0, tick=0, score=0. btn_start is ignored while mode_sel == 2'b00. btn_stop is ignored.
- RUN: mode is frozen. Step length N is TICK_LOW, TICK_NORMAL or TICK_HIGH according to mode. The tick counter counts 0..N-1; on reaching N-1 it returns to 0 and I advances (see Configuration).
- RUN + btn_stop: go to HOLD with I unchanged and hold=0. If I == TARGET, score <= min(score+1, 15) and hit=1 for exactly one cycle.
- HOLD: I is frozen and the hold counter counts to HOLD_CYCLES-1. After that, return to RUN with I=0, tick=0 and the direction reset to up. btn_stop is ignored in HOLD.
- btn_start in RUN or HOLD aborts to IDLE: I=0, score retained, counters cleared.
- Simultaneous events:
  - btn_start and btn_stop in the same cycle: btn_start wins (abort); no score change.
  - btn_stop in the same cycle as a step tick: stop wins. I does not advance, and the hit compare uses the pre-step I.
- Tick counter width is $clog2(TICK_LOW+1). score saturates and never wraps.
- rst asserted mid-operation returns every register to its reset value immediately, independent of clk.

## Timing
- All outputs are registered and change on the rising edge after the triggering input cycle (1-cycle latency). There are no combinational input-to-output paths.
- idle and start are mutually exclusive every cycle.
- In RUN, I changes exactly every N cycles. The first step occurs N cycles after the RUN entry edge.
- HOLD lasts exactly HOLD_CYCLES cycles. I=0 is visible on the edge that re-enters RUN.
- The hit pulse coincides with the HOLD entry edge. The score update is visible on the same edge.

## Configuration
- Macro: SWEEP_BOUNCE_EN.
  - Defined: the sweep ping-pongs. A direction register (reset and RUN-entry value: up) steps I 0→15, reverses at 15, steps 15→0, reverses at 0. Each endpoint is shown for exactly one step period.
  - Undefined: I increments and wraps 15→0. No direction register is synthesised.

## Test plan
- Apply rst mid-RUN, asynchronous to clk → I=0, start=0, idle=1, mode=0, score=0 before the next edge.
- TICK_HIGH=3, mode_sel=2'b11, btn_start → start=1 the next cycle; I reaches 1, 2, 3 at cycles 3, 6, 9; wraps 15→0 after 48 cycles (bounce build: reaches 15 then 14).
- btn_stop when I=7 with TARGET=7 → hit pulses one cycle, score=1, I holds at 7 for HOLD_CYCLES=5 cycles, then I=0 and RUN resumes.
- btn_stop when I=4 → no hit, score unchanged. Sixteen hits starting at score=14 → score stays at 15.
- btn_start with mode_sel=2'b00 in IDLE → state stays IDLE, idle=1. btn_start and btn_stop in the same cycle during RUN → IDLE, score retained.
- btn_stop in the same cycle as a step tick at I=6 → I stays 6, enters HOLD, no hit with TARGET=7.
